// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state, opcode and mux-select encodings for main_fsm
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam logic [1:0] SRCA_RN     = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/main_fsm_outdec.sv
// rtl/main_fsm_outdec.sv - combinational state-to-control decode for main_fsm
module main_fsm_outdec
  import ctrl_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic       ready_i,
  input  logic [1:0] op_i,
  output logic       irwrite_o,
  output logic       nextpc_o,
  output logic       regw_o,
  output logic       memw_o,
  output logic       branch_o,
  output logic       adrsrc_o,
  output logic [1:0] alusrca_o,
  output logic [1:0] alusrcb_o,
  output logic [1:0] resultsrc_o,
  output logic       aluop_o,
  output logic       illegal_o
);

  always_comb begin
    irwrite_o   = 1'b0;
    nextpc_o    = 1'b0;
    regw_o      = 1'b0;
    memw_o      = 1'b0;
    branch_o    = 1'b0;
    adrsrc_o    = 1'b0;
    alusrca_o   = SRCA_RN;
    alusrcb_o   = SRCB_REG;
    resultsrc_o = RES_ALUOUT;
    aluop_o     = 1'b0;
    illegal_o   = 1'b0;
    case (state_i)
      S_FETCH: begin
        irwrite_o   = ready_i;
        nextpc_o    = ready_i;
        alusrca_o   = SRCA_PC;
        alusrcb_o   = SRCB_FOUR;
        resultsrc_o = RES_ALU;
      end
      S_DECODE: begin
        alusrca_o   = SRCA_PC;
        alusrcb_o   = SRCB_FOUR;
        resultsrc_o = RES_ALU;
        illegal_o   = (op_i == OP_ILL);
      end
      S_MEMADR: begin
        alusrcb_o = SRCB_IMM;
      end
      S_MEMRD: begin
        adrsrc_o = 1'b1;
      end
      S_MEMWB: begin
        resultsrc_o = RES_DATA;
        regw_o      = 1'b1;
      end
      S_MEMWR: begin
        adrsrc_o = 1'b1;
        memw_o   = 1'b1;
      end
      S_EXECR: begin
        aluop_o = 1'b1;
      end
      S_EXECI: begin
        alusrcb_o = SRCB_IMM;
        aluop_o   = 1'b1;
      end
      S_ALUWB: begin
        regw_o = 1'b1;
      end
      S_BRANCH: begin
        alusrca_o   = SRCA_ALUOUT;
        alusrcb_o   = SRCB_IMM;
        resultsrc_o = RES_ALU;
        branch_o    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/main_fsm.sv
// rtl/main_fsm.sv - multicycle ARMv4 main control FSM with memory-ready stalls
module main_fsm
  import ctrl_pkg::*;
#(
  parameter int ENABLE_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       illegal,
  output logic [3:0] state_o
);

  state_t state_q, state_d;
  logic   ready;
  logic   irwrite_raw, nextpc_raw, regw_raw, memw_raw, branch_raw, illegal_raw;
  logic   unused_funct;

  assign ready        = (ENABLE_WAIT != 0) ? mem_ready : 1'b1;
  assign unused_funct = ^Funct[4:1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_DP:   state_d = Funct[5] ? S_EXECI : S_EXECR;
          OP_MEM:  state_d = S_MEMADR;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = ready ? S_FETCH : S_MEMWR;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  main_fsm_outdec u_outdec (
    .state_i     (state_q),
    .ready_i     (ready),
    .op_i        (Op),
    .irwrite_o   (irwrite_raw),
    .nextpc_o    (nextpc_raw),
    .regw_o      (regw_raw),
    .memw_o      (memw_raw),
    .branch_o    (branch_raw),
    .adrsrc_o    (AdrSrc),
    .alusrca_o   (ALUSrcA),
    .alusrcb_o   (ALUSrcB),
    .resultsrc_o (ResultSrc),
    .aluop_o     (ALUOp),
    .illegal_o   (illegal_raw)
  );

  // Enables are gated by reset itself so nothing leaks between assertion and the state flop clearing.
  assign IRWrite = reset & irwrite_raw;
  assign NextPC  = reset & nextpc_raw;
  assign RegW    = reset & regw_raw;
  assign MemW    = reset & memw_raw;
  assign Branch  = reset & branch_raw;
  assign illegal = reset & illegal_raw;
  assign state_o = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// tb/tb_main_fsm.sv - randomized self-checking bench for main_fsm against a cycle-trace model
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       mem_ready;
  logic       IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUOp, illegal;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0] state_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         st;
    logic       rdy;
    logic [1:0] op;
    logic [5:0] funct;
  } cyc_t;

  cyc_t q[$];

  main_fsm #(.ENABLE_WAIT(1)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .mem_ready(mem_ready),
    .IRWrite(IRWrite), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .Branch(Branch),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ALUOp(ALUOp), .illegal(illegal), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Output vector order: IRWrite NextPC RegW MemW Branch AdrSrc ALUSrcA ALUSrcB ResultSrc ALUOp illegal
  function automatic logic [13:0] exp_out(input int s, input logic rdy, input logic [1:0] op);
    logic irw, npc, rw, mw, br, adr, aop, ill;
    logic [1:0] sa, sb, rs;
    {irw, npc, rw, mw, br, adr, aop, ill} = '0;
    sa = 2'b00; sb = 2'b00; rs = 2'b00;
    case (s)
      0: begin irw = rdy; npc = rdy; sa = 2'b01; sb = 2'b10; rs = 2'b10; end
      1: begin sa = 2'b01; sb = 2'b10; rs = 2'b10; ill = (op == 2'b11); end
      2: sb = 2'b01;
      3: adr = 1'b1;
      4: begin rs = 2'b01; rw = 1'b1; end
      5: begin adr = 1'b1; mw = 1'b1; end
      6: aop = 1'b1;
      7: begin sb = 2'b01; aop = 1'b1; end
      8: rw = 1'b1;
      9: begin sa = 2'b10; sb = 2'b01; rs = 2'b10; br = 1'b1; end
      default: ;
    endcase
    return {irw, npc, rw, mw, br, adr, sa, sb, rs, aop, ill};
  endfunction

  // Op/Funct only matter in DECODE/MEMADR; elsewhere drive noise to prove they are ignored.
  task automatic push(input int st, input logic rdy, input logic [1:0] op, input logic [5:0] funct);
    cyc_t c;
    c.st  = st;
    c.rdy = rdy;
    if (st == 1 || st == 2) begin
      c.op = op; c.funct = funct;
    end else begin
      c.op = 2'($urandom); c.funct = 6'($urandom);
    end
    q.push_back(c);
  endtask

  task automatic build_instr(input logic [1:0] op, input logic [5:0] funct, input int nf, input int nm);
    for (int i = 0; i < nf; i++) push(0, 1'b0, op, funct);
    push(0, 1'b1, op, funct);
    push(1, 1'($urandom), op, funct);
    case (op)
      2'b00: begin
        push(funct[5] ? 7 : 6, 1'($urandom), op, funct);
        push(8, 1'($urandom), op, funct);
      end
      2'b01: begin
        push(2, 1'($urandom), op, funct);
        if (funct[0]) begin
          for (int i = 0; i < nm; i++) push(3, 1'b0, op, funct);
          push(3, 1'b1, op, funct);
          push(4, 1'($urandom), op, funct);
        end else begin
          for (int i = 0; i < nm; i++) push(5, 1'b0, op, funct);
          push(5, 1'b1, op, funct);
        end
      end
      2'b10: push(9, 1'($urandom), op, funct);
      default: ;
    endcase
  endtask

  task automatic run(input int limit);
    int n = 0;
    while (q.size() > 0 && n < limit) begin
      cyc_t c;
      c = q.pop_front();
      Op = c.op; Funct = c.funct; mem_ready = c.rdy;
      @(negedge clk);
      check("state", state_o, c.st);
      check("outputs", {IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUSrcA, ALUSrcB,
                        ResultSrc, ALUOp, illegal}, exp_out(c.st, c.rdy, c.op));
      @(posedge clk); #1;
      n++;
    end
    q.delete();
  endtask

  initial begin
    reset = 1'b0; Op = 2'b00; Funct = 6'd0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", state_o, 0);
    check("rst_enables", {IRWrite, NextPC, RegW, MemW, Branch, illegal}, 6'b0);
    check("rst_selects", {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp}, {1'b0, 2'b01, 2'b10, 2'b10, 1'b0});
    reset = 1'b1;

    build_instr(2'b00, 6'b001000, 0, 0); run(1000);
    build_instr(2'b01, 6'b011001, 0, 2); run(1000);
    build_instr(2'b01, 6'b011000, 0, 3); run(1000);
    build_instr(2'b10, 6'b000000, 0, 0); run(1000);
    build_instr(2'b11, 6'b101010, 0, 0); run(1000);

    for (int k = 0; k < 150; k++) begin
      int nf = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      build_instr(2'($urandom), 6'($urandom), nf, $urandom_range(0, 3));
      run(1000);
    end

    // Store stalled in MEMWR, then asynchronous reset between edges.
    build_instr(2'b01, 6'b000000, 0, 3);
    run(4);
    check("pre_rst_memw", {state_o, MemW}, {4'd5, 1'b1});
    #2;
    reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("async_rst_state", state_o, 0);
    check("async_rst_memw", MemW, 0);
    check("async_rst_irwrite", {IRWrite, NextPC, RegW}, 3'b0);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("wait_fetch_state", state_o, 0);
      check("wait_fetch_irwrite", IRWrite, 0);
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    @(negedge clk);
    check("fetch_ready_irwrite", IRWrite, 1);
    @(posedge clk); #1;
    check("fetch_to_decode", state_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/main_fsm.md
Name: main_fsm

Overview:
- Multicycle main control FSM for the ARMv4 message-decoder core.
- Sits directly upstream of the ALU decoder. Decodes Op/Funct from the instruction register and sequences fetch, decode, execute, memory and writeback.
- Drives ALUOp, which selects between a forced ADD (ALUOp=0) and Funct-based decode (ALUOp=1), plus all datapath mux selects and write enables.
- Adds a memory-ready handshake so that slow instruction/data memory can stall the sequence.

Parameters:
- ENABLE_WAIT, 1, 1: mem_ready gates progress out of FETCH/MEMRD/MEMWR; 0: mem_ready ignored (treated as 1).

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  asynchronous, active-low reset
- Op  input  2  instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 illegal
- Funct  input  6  instr[25:20]; Funct[5]=I, Funct[0]=S/L
- mem_ready  input  1  memory access completes this cycle
- IRWrite  output  1  load instruction register
- NextPC  output  1  PC update request (gated with branch logic downstream)
- RegW  output  1  register-file write request
- MemW  output  1  data-memory write request
- Branch  output  1  branch-taken request (conditioned downstream)
- AdrSrc  output  1  0=PC, 1=ALU result register
- ALUSrcA  output  2  00=Rn, 01=PC, 10=ALUOut
- ALUSrcB  output  2  00=Rm/shifted, 01=ExtImm, 10=const 4
- ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALU result
- ALUOp  output  1  to ALU decoder
- illegal  output  1  one-cycle pulse in DECODE when Op=11
- state_o  output  4  current state encoding, for debug and bench

Behaviour:
- State register is updated on the rising clock edge. While reset=0, the state is asynchronously FETCH.
- Outputs are Moore, decoded combinationally from the state, so a new state's outputs are visible in the same cycle it is entered. Unlisted outputs are 0.
- While reset=0, IRWrite, NextPC, RegW, MemW, Branch and illegal are forced 0. Mux selects take their FETCH values.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Codes 10–15 are unreachable and transition to FETCH on the next edge, with all enables 0.
- FETCH:
  - Outputs: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUOp=0.
  - IRWrite and NextPC = mem_ready (forced 1 when ENABLE_WAIT=0).
  - Transition: to DECODE if ready, else stay in FETCH.
- DECODE:
  - Outputs: ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUOp=0.
  - Transitions: Op=00 & Funct[5]=0 -> EXECR; Op=00 & Funct[5]=1 -> EXECI; Op=01 -> MEMADR; Op=10 -> BRANCH; Op=11 -> FETCH with illegal=1 for this cycle.
- MEMADR:
  - Outputs: ALUSrcA=00, ALUSrcB=01, ALUOp=0.
  - Transitions: Funct[0]=1 -> MEMRD, else -> MEMWR.
- MEMRD:
  - Outputs: AdrSrc=1, ResultSrc=00.
  - Transition: to MEMWB if ready, else stay in MEMRD.
- MEMWB:
  - Outputs: ResultSrc=01, RegW=1.
  - Transition: -> FETCH.
- MEMWR:
  - Outputs: AdrSrc=1, ResultSrc=00, MemW=1. MemW is held 1 throughout the stall.
  - Transition: to FETCH if ready, else stay in MEMWR.
- EXECR:
  - Outputs: ALUSrcA=00, ALUSrcB=00, ALUOp=1.
  - Transition: -> ALUWB.
- EXECI:
  - Outputs: ALUSrcA=00, ALUSrcB=01, ALUOp=1.
  - Transition: -> ALUWB.
- ALUWB:
  - Outputs: ResultSrc=00, RegW=1.
  - Transition: -> FETCH.
- BRANCH:
  - Outputs: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, ALUOp=0, Branch=1.
  - Transition: -> FETCH.
- Latencies with mem_ready held at 1:
  - Data-processing: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - Illegal: 2 cycles.
  - Each stalled cycle adds 1.
- Op/Funct are sampled only in DECODE and MEMADR; changes in any other state are ignored.
- Reset asserted mid-instruction: return to FETCH immediately; no partial RegW or MemW is issued after reset assertion.
- First rising edge after reset release: evaluates FETCH normally.

Decomposition:
- Shared package (ctrl_pkg):
  - state_t enum with the codes above.
  - Op encodings: OP_DP, OP_MEM, OP_BR, OP_ILL.
  - Mux-select constants: SRCA_RN/PC/ALUOUT, SRCB_REG/IMM/FOUR, RES_ALUOUT/DATA/ALU.
- Sub-module main_fsm_outdec: purely combinational state-to-output decode, so the output table is reviewed and tested separately from the next-state logic.

Test Plan:
- ADD (Op=00, Funct=001000), mem_ready=1 -> states 0,1,6,8,0. ALUOp=1 only in EXECR; RegW=1 only in ALUWB; IRWrite=1 for exactly 1 cycle.
- LDR (Op=01, Funct=011001), mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0. AdrSrc=1 throughout MEMRD; RegW=1 with ResultSrc=01 in MEMWB.
- STR (Funct[0]=0), mem_ready=0 for 3 cycles in MEMWR -> MemW held 1 for 4 cycles, then FETCH. RegW never asserted.
- B (Op=10) -> states 0,1,9,0. Branch=1, ALUSrcA=10, ALUSrcB=01 in BRANCH.
- Op=11 -> states 0,1,0; illegal=1 for exactly the DECODE cycle; no RegW, MemW or Branch.
- reset driven low asynchronously mid-MEMWR -> state_o=0 and MemW=0 without waiting for a clock edge. After reset release with mem_ready=0 (ENABLE_WAIT=1), the FSM stays in FETCH with IRWrite=0.
